// File: rtl/sbp_pkg.sv
// sbp_pkg: shared types and helpers for the SBP lookup front end.
//   result_bits() - width of a lookup result {hit, location, kind, stage}
//   result_t      - result layout at the default widths
//   upd_cmd_t     - control-plane table update {stage, addr, data}
//   sched_state_e - update sequencer states
package sbp_pkg;

  localparam int DEF_LOCATION_BITS = 11;
  localparam int DEF_STAGE_ID_BITS = 6;
  localparam int DEF_ADDR_BITS     = 11;
  localparam int DEF_DATA_BITS     = 64;

  function automatic int result_bits(input int location_bits, input int stage_id_bits);
    return 1 + location_bits + 2 + stage_id_bits;
  endfunction

  typedef struct packed {
    logic                         hit;
    logic [DEF_LOCATION_BITS-1:0] location;
    logic [1:0]                   kind;
    logic [DEF_STAGE_ID_BITS-1:0] stage;
  } result_t;

  typedef struct packed {
    logic [DEF_STAGE_ID_BITS-1:0] stage;
    logic [DEF_ADDR_BITS-1:0]     addr;
    logic [DEF_DATA_BITS-1:0]     data;
  } upd_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUBBLE,
    ST_WAIT,
    ST_WRITE
  } sched_state_e;

endpackage

// File: rtl/sbp_rr_arbiter.sv
// sbp_rr_arbiter: round-robin arbiter with an internal rotating pointer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (pointer -> 0)
//   req         - request vector, one bit per requester
//   enable      - when low no grant is issued and the pointer holds
//   grant       - one-hot grant (or zero)
//   grant_idx   - index of the granted requester
//   grant_valid - a grant is issued this cycle
module sbp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_valid = found && enable;
    grant       = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sbp_lookup_sched.sv
// sbp_lookup_sched: front-end scheduler for the SBP lookup pipeline.
// Arbitrates lookup requesters round-robin (one issue per cycle), tracks
// in-flight lookups with a tag delay line so each result returns to its
// requester, and serialises table updates by injecting a bubble and writing
// the target stage RAM while that bubble occupies the stage.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid_i/ready_o       - per-requester request handshake
//   req_ip_addr_i             - packed keys, requester i at [32*i +: 32]
//   lk_valid_o, lk_ip_addr_o  - lookup issued into stage 0
//   lk_result_i, lk_ip_addr_i - result and key leaving the last stage
//   resp_*_o                  - registered response, no backpressure
//   upd_*                     - table update command handshake
//   wr_en_o/addr_o/data_o     - stage RAM port-B write
// Optional build macro SBP_SCHED_STATS_EN adds stat_lookups_o,
// stat_bubbles_o and stat_max_wait_o saturating counters.
module sbp_lookup_sched
  import sbp_pkg::*;
#(
  parameter int NUM_STAGES    = 32,
  parameter int STAGE_LATENCY = 2,
  parameter int NUM_REQ       = 4,
  parameter int ADDR_BITS     = 11,
  parameter int DATA_BITS     = 64,
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  localparam int RESULT_BITS  = result_bits(LOCATION_BITS, STAGE_ID_BITS),
  localparam int ID_BITS      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*32-1:0]    req_ip_addr_i,
  output logic [31:0]              lk_ip_addr_o,
  output logic                     lk_valid_o,
  input  logic [RESULT_BITS-1:0]   lk_result_i,
  input  logic [31:0]              lk_ip_addr_i,
  output logic                     resp_valid_o,
  output logic [ID_BITS-1:0]       resp_id_o,
  output logic [RESULT_BITS-1:0]   resp_result_o,
  output logic [31:0]              resp_ip_addr_o,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_i,
  input  logic [ADDR_BITS-1:0]     upd_addr_i,
  input  logic [DATA_BITS-1:0]     upd_data_i,
  output logic [NUM_STAGES-1:0]    wr_en_o,
  output logic [ADDR_BITS-1:0]     wr_addr_o,
  output logic [DATA_BITS-1:0]     wr_data_o
`ifdef SBP_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_lookups_o,
  output logic [15:0]              stat_bubbles_o,
  output logic [15:0]              stat_max_wait_o
`endif
);

  localparam int LOOKUP_LATENCY = NUM_STAGES * STAGE_LATENCY;
  localparam int CNT_W          = STAGE_ID_BITS + $clog2(STAGE_LATENCY + 1);

  sched_state_e state, state_nx;
  logic [STAGE_ID_BITS-1:0] upd_stage_q;
  logic [ADDR_BITS-1:0]     upd_addr_q;
  logic [DATA_BITS-1:0]     upd_data_q;
  logic [CNT_W-1:0]         cnt, cnt_nx, upd_delay;
  logic                     upd_accept, wr_fire, stage_ok, arb_en;

  logic [NUM_REQ-1:0] grant;
  logic [ID_BITS-1:0] grant_idx;
  logic               grant_valid;

  logic [LOOKUP_LATENCY-1:0]              tag_v;
  logic [LOOKUP_LATENCY-1:0][ID_BITS-1:0] tag_id;

  // The bubble slot is the only cycle in which no lookup may be granted.
  assign arb_en = !rst && (state != ST_BUBBLE);

  sbp_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_BITS)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid_i),
    .enable      (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready_o  = grant;
  assign lk_valid_o   = grant_valid;
  assign lk_ip_addr_o = grant_valid ? req_ip_addr_i[grant_idx*32 +: 32] : 32'h0;

  // Cycles from the bubble slot until the bubble sits in the target stage.
  assign upd_delay = CNT_W'(upd_stage_q) * CNT_W'(STAGE_LATENCY);
  assign stage_ok  = int'(upd_stage_q) < NUM_STAGES;

  // Update sequencer. Stage 0 is written in the bubble slot itself, since
  // the lookup issued right after the bubble reads stage 0 in the next
  // cycle; that case returns straight to idle.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    upd_accept = 1'b0;
    wr_fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (upd_valid_i) begin
          upd_accept = 1'b1;
          state_nx   = ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        if (upd_delay == '0) begin
          wr_fire  = 1'b1;
          state_nx = ST_IDLE;
        end else if (upd_delay == CNT_W'(1)) begin
          state_nx = ST_WRITE;
        end else begin
          cnt_nx   = upd_delay - CNT_W'(1);
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= CNT_W'(1)) state_nx = ST_WRITE;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      ST_WRITE: begin
        wr_fire  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (rst) begin
      upd_accept = 1'b0;
      wr_fire    = 1'b0;
    end
  end

  assign upd_ready_o = upd_accept;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      wr_en_o[s] = wr_fire && stage_ok && (int'(upd_stage_q) == s);
    end
    wr_addr_o = (wr_fire && stage_ok) ? upd_addr_q : '0;
    wr_data_o = (wr_fire && stage_ok) ? upd_data_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      upd_stage_q <= '0;
      upd_addr_q  <= '0;
      upd_data_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (upd_accept) begin
        upd_stage_q <= upd_stage_i;
        upd_addr_q  <= upd_addr_i;
        upd_data_q  <= upd_data_i;
      end
    end
  end

  // Tag line runs in lockstep with the stage chain; its tail lines up with
  // the result on lk_result_i, which is then registered onto resp_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v          <= '0;
      tag_id         <= '0;
      resp_valid_o   <= 1'b0;
      resp_id_o      <= '0;
      resp_result_o  <= '0;
      resp_ip_addr_o <= '0;
    end else begin
      tag_v          <= {tag_v[LOOKUP_LATENCY-2:0], grant_valid};
      tag_id         <= {tag_id[LOOKUP_LATENCY-2:0], grant_idx};
      resp_valid_o   <= tag_v[LOOKUP_LATENCY-1];
      resp_id_o      <= tag_v[LOOKUP_LATENCY-1] ? tag_id[LOOKUP_LATENCY-1] : '0;
      resp_result_o  <= tag_v[LOOKUP_LATENCY-1] ? lk_result_i : '0;
      resp_ip_addr_o <= tag_v[LOOKUP_LATENCY-1] ? lk_ip_addr_i : '0;
    end
  end

`ifdef SBP_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] wait_cnt;
  logic [15:0]              wait_max;

  always_comb begin
    wait_max = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wait_cnt[i] > wait_max) wait_max = wait_cnt[i];
    end
  end

  // Wait counters track the current unbroken run of valid-without-grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_o  <= '0;
      stat_bubbles_o  <= '0;
      stat_max_wait_o <= '0;
      wait_cnt        <= '0;
    end else begin
      if (grant_valid && !(&stat_lookups_o)) stat_lookups_o <= stat_lookups_o + 1'b1;
      if (upd_accept && !(&stat_bubbles_o))  stat_bubbles_o <= stat_bubbles_o + 1'b1;
      if (wait_max > stat_max_wait_o)        stat_max_wait_o <= wait_max;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && !grant[i]) begin
          if (!(&wait_cnt[i])) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sbp_lookup_sched.sv
// tb_sbp_lookup_sched: randomized self-checking bench for sbp_lookup_sched.
// The bench emulates the stage chain (a delay line plus one probed RAM word
// at stage 5, address 0x10) and checks the DUT against a reference model of
// the scheduling rules: round-robin grants, bubble slots, write timing,
// old/new table visibility around the bubble, and response routing.
module tb_sbp_lookup_sched;

  localparam int NUM_STAGES = 32;
  localparam int SL         = 2;
  localparam int NUM_REQ    = 4;
  localparam int LL         = NUM_STAGES * SL;
  localparam int RB         = 20;
  localparam int MAXC       = 4096;
  localparam int PROBE_STAGE = 5;
  localparam logic [10:0] PROBE_ADDR = 11'h010;
  localparam logic [63:0] OLD_WORD   = 64'h1111_2222_3333_4444;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*32-1:0] req_ip_addr_i;
  logic [31:0]           lk_ip_addr_o;
  logic                  lk_valid_o;
  logic [RB-1:0]         lk_result_i;
  logic [31:0]           lk_ip_addr_i;
  logic                  resp_valid_o;
  logic [1:0]            resp_id_o;
  logic [RB-1:0]         resp_result_o;
  logic [31:0]           resp_ip_addr_o;
  logic                  upd_valid_i;
  logic                  upd_ready_o;
  logic [5:0]            upd_stage_i;
  logic [10:0]           upd_addr_i;
  logic [63:0]           upd_data_i;
  logic [NUM_STAGES-1:0] wr_en_o;
  logic [10:0]           wr_addr_o;
  logic [63:0]           wr_data_o;

  sbp_lookup_sched dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_ip_addr_i  (req_ip_addr_i),
    .lk_ip_addr_o   (lk_ip_addr_o),
    .lk_valid_o     (lk_valid_o),
    .lk_result_i    (lk_result_i),
    .lk_ip_addr_i   (lk_ip_addr_i),
    .resp_valid_o   (resp_valid_o),
    .resp_id_o      (resp_id_o),
    .resp_result_o  (resp_result_o),
    .resp_ip_addr_o (resp_ip_addr_o),
    .upd_valid_i    (upd_valid_i),
    .upd_ready_o    (upd_ready_o),
    .upd_stage_i    (upd_stage_i),
    .upd_addr_i     (upd_addr_i),
    .upd_data_i     (upd_data_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stage-chain emulation
  bit          env_v    [MAXC];
  logic [31:0] env_key  [MAXC];
  logic [63:0] env_word [MAXC];
  logic [63:0] ram_probe = OLD_WORD;

  // reference model
  bit          exp_v   [MAXC];
  logic [1:0]  exp_id  [MAXC];
  logic [31:0] exp_key [MAXC];
  logic [RB-1:0] exp_res [MAXC];
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_bubble, m_write, m_stage;
  logic [10:0] m_addr;
  logic [63:0] m_data;
  logic [63:0] m_word = OLD_WORD;

  int          g, c0, c1;
  bit          bubble, exp_upd;
  logic [NUM_REQ-1:0]    exp_ready;
  logic [NUM_STAGES-1:0] exp_wr;

  function automatic logic [RB-1:0] mix(input logic [31:0] k, input logic [63:0] w);
    return k[19:0] ^ w[19:0] ^ w[51:32];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic checkResp();
    checkOutput("resp_valid", 64'(resp_valid_o), 64'(exp_v[cyc]));
    if (exp_v[cyc]) begin
      checkOutput("resp_id", 64'(resp_id_o), 64'(exp_id[cyc]));
      checkOutput("resp_ip_addr", 64'(resp_ip_addr_o), 64'(exp_key[cyc]));
      checkOutput("resp_result", 64'(resp_result_o), 64'(exp_res[cyc]));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic uv, input logic [5:0] us,
                               input logic [10:0] ua, input logic [63:0] ud);
    req_valid_i = v;
    upd_valid_i = uv;
    upd_stage_i = us;
    upd_addr_i  = ua;
    upd_data_i  = ud;
    for (int i = 0; i < NUM_REQ; i++) req_ip_addr_i[i*32 +: 32] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(4'h0, 1'b0, 6'd0, 11'd0, 64'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle: emulate the stage chain, then compare against the model.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC - LL - 2) begin
      if (lk_valid_o) begin
        env_v[cyc]   = 1'b1;
        env_key[cyc] = lk_ip_addr_o;
      end
      c0 = cyc - PROBE_STAGE * SL;
      if (c0 >= 0 && env_v[c0]) env_word[c0] = ram_probe;
      if (wr_en_o[PROBE_STAGE] && wr_addr_o == PROBE_ADDR) ram_probe = wr_data_o;
      c1 = cyc - LL;
      if (c1 >= 0 && env_v[c1]) begin
        lk_ip_addr_i = env_key[c1];
        lk_result_i  = mix(env_key[c1], env_word[c1]);
      end else begin
        lk_ip_addr_i = 32'h0;
        lk_result_i  = '0;
      end

      if (rst) begin
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'h0);
        checkOutput("rst_lk_valid", 64'(lk_valid_o), 64'h0);
        checkOutput("rst_upd_ready", 64'(upd_ready_o), 64'h0);
        checkOutput("rst_wr_en", 64'(wr_en_o), 64'h0);
        checkResp();
        m_ptr  = 0;
        m_busy = 1'b0;
        for (int i = cyc + 1; i < MAXC; i++) exp_v[i] = 1'b0;
      end else begin
        bubble = m_busy && (cyc == m_bubble);
        g = -1;
        if (!bubble) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (g < 0 && req_valid_i[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
          end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
        checkOutput("lk_valid", 64'(lk_valid_o), 64'(g >= 0));
        if (g >= 0) checkOutput("lk_ip_addr", 64'(lk_ip_addr_o), 64'(req_ip_addr_i[g*32 +: 32]));

        exp_upd = !m_busy && upd_valid_i;
        checkOutput("upd_ready", 64'(upd_ready_o), 64'(exp_upd));

        exp_wr = '0;
        if (m_busy && cyc == m_write && m_stage < NUM_STAGES) exp_wr[m_stage] = 1'b1;
        checkOutput("wr_en", 64'(wr_en_o), 64'(exp_wr));
        if (exp_wr != '0) begin
          checkOutput("wr_addr", 64'(wr_addr_o), 64'(m_addr));
          checkOutput("wr_data", wr_data_o, m_data);
        end
        checkResp();

        // Lookups issued after the bubble slot must see the new word.
        if (bubble && m_stage == PROBE_STAGE && m_addr == PROBE_ADDR) m_word = m_data;
        if (m_busy && cyc == m_write) m_busy = 1'b0;
        if (exp_upd) begin
          m_busy   = 1'b1;
          m_stage  = int'(upd_stage_i);
          m_addr   = upd_addr_i;
          m_data   = upd_data_i;
          m_bubble = cyc + 1;
          m_write  = cyc + 1 + m_stage * SL;
        end
        if (g >= 0) begin
          exp_v[cyc + LL + 1]   = 1'b1;
          exp_id[cyc + LL + 1]  = 2'(g);
          exp_key[cyc + LL + 1] = req_ip_addr_i[g*32 +: 32];
          exp_res[cyc + LL + 1] = mix(req_ip_addr_i[g*32 +: 32], m_word);
          m_ptr = (g + 1) % NUM_REQ;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    req_valid_i   = '0;
    req_ip_addr_i = '0;
    upd_valid_i   = 1'b0;
    upd_stage_i   = '0;
    upd_addr_i    = '0;
    upd_data_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");

    // single requester 2
    req_valid_i = 4'b0100;
    for (int i = 0; i < NUM_REQ; i++) req_ip_addr_i[i*32 +: 32] = $urandom;
    req_ip_addr_i[95:64] = 32'h0A00_0001;
    @(posedge clk);
    #1;
    idleCycles(70);

    // all requesters continuously for 8 cycles
    repeat (8) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);
    idleCycles(70);

    // random request traffic
    repeat (200) applyStimulus(4'($urandom), 1'b0, 6'd0, 11'd0, 64'd0);

    // update of the probed word with lookups on both sides of the bubble
    repeat (5) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);
    applyStimulus(4'hF, 1'b1, 6'd5, 11'h010, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (20) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);

    // stage 0 update followed by an update that must be held
    applyStimulus(4'hF, 1'b1, 6'd0, 11'h033, 64'h0123_4567_89AB_CDEF);
    repeat (4) applyStimulus(4'hF, 1'b1, 6'd3, 11'h020, 64'hFEDC_BA98_7654_3210);
    repeat (10) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);

    // out-of-range stage: bubble but no write
    applyStimulus(4'hF, 1'b1, 6'd40, 11'h010, 64'h0BAD_0BAD_0BAD_0BAD);
    repeat (90) applyStimulus(4'($urandom), 1'b0, 6'd0, 11'd0, 64'd0);

    // reset with lookups in flight
    repeat (10) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);
    rst = 1'b1;
    applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);
    rst = 1'b0;
    repeat (3) applyStimulus(4'hF, 1'b0, 6'd0, 11'd0, 64'd0);
    idleCycles(80);

    // mixed random traffic and updates
    repeat (300) begin
      applyStimulus(4'($urandom),
                    1'($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) == 0) ? 6'd5 : 6'($urandom_range(0, 40)),
                    ($urandom_range(0, 1) == 0) ? 11'h010 : 11'($urandom),
                    {$urandom, $urandom});
    end
    idleCycles(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
